// File: rtl/cavlc_nc_top_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : cavlc_nc_top_ctrl_if
//  Brief    : Bundle between the CAVLC MB sequencer, the top-neighbour NC
//             controller and the 2-port NC line-buffer RAM.
//             slave  = controller view, master = sequencer/RAM side view.
//  Revision : 1.0  initial release
// ============================================================================
interface cavlc_nc_top_ctrl_if #(
   parameter int MB_X_W = 7,
   parameter int DATA_W = 36
) ();

   // sequencer side
   logic              mb_start_i;
   logic [MB_X_W-1:0] mb_x_i;
   logic [7:0]        mb_y_i;
   logic              mb_done_i;
   logic [DATA_W-1:0] bot_nc_i;
   logic [DATA_W-1:0] top_nc_o;
   logic              top_avail_o;
   logic              top_valid_o;

   // RAM side
   logic              rd_o;
   logic [MB_X_W-1:0] raddr_o;
   logic [DATA_W-1:0] rdata_i;
   logic              we_o;
   logic [MB_X_W-1:0] waddr_o;
   logic [DATA_W-1:0] wdata_o;

   modport slave (
      input  mb_start_i, mb_x_i, mb_y_i, mb_done_i, bot_nc_i, rdata_i,
      output top_nc_o, top_avail_o, top_valid_o,
      output rd_o, raddr_o, we_o, waddr_o, wdata_o
   );

   modport master (
      output mb_start_i, mb_x_i, mb_y_i, mb_done_i, bot_nc_i, rdata_i,
      input  top_nc_o, top_avail_o, top_valid_o,
      input  rd_o, raddr_o, we_o, waddr_o, wdata_o
   );

endinterface
`default_nettype wire

// File: rtl/cavlc_nc_top_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cavlc_nc_top_ctrl
//  Brief    : Read/write controller for the CAVLC top-neighbour NC line
//             buffer. Writes each finished MB's bottom-row TotalCoeff word at
//             its column, fetches the word above a starting MB.
//  Option   : CAVLC_NC_FWD_EN - write-first forwarding when the fetch and a
//             write hit the same address in the same cycle. Without it that
//             case is illegal and the RAM's old data is returned.
//  Revision : 1.0  initial release
// ============================================================================
module cavlc_nc_top_ctrl #(
   parameter int MB_X_W = 7,
   parameter int MB_MAX = 120,
   parameter int DATA_W = 36
) (
   input  logic                clk,
   input  logic                rst_n,
   cavlc_nc_top_ctrl_if.slave  bus
);

   localparam logic [MB_X_W-1:0] MB_MAX_C = MB_MAX[MB_X_W-1:0];

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RD    = 2'd1,
      S_WAIT  = 2'd2,
      S_VALID = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [MB_X_W-1:0]   mb_x_q;

   logic                rd_q, rd_d;
   logic [MB_X_W-1:0]   raddr_q, raddr_d;
   logic [DATA_W-1:0]   top_nc_q, top_nc_d;
   logic                avail_q, avail_d;
   logic                valid_q, valid_d;

   logic                we_q;
   logic [MB_X_W-1:0]   waddr_q;
   logic [DATA_W-1:0]   wdata_q;

   logic                read_ok;
   logic [DATA_W-1:0]   capture_data;

   // A fetch is needed only when a row exists above and the column is in range
   assign read_ok = (bus.mb_y_i != 8'd0) && (bus.mb_x_i < MB_MAX_C);

`ifdef CAVLC_NC_FWD_EN
   logic                fwd_hit_q;
   logic [DATA_W-1:0]   fwd_data_q;

   // Remember a same-address write landing in the RD cycle; the RAM returns pre-write data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_hit_q  <= 1'b0;
         fwd_data_q <= '0;
      end else begin
         fwd_hit_q  <= rd_q && we_q && (raddr_q == waddr_q);
         fwd_data_q <= wdata_q;
      end
   end

   assign capture_data = fwd_hit_q ? fwd_data_q : bus.rdata_i;
`else
   assign capture_data = bus.rdata_i;
`endif

   // Read FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next state and next read-side output values; a new start always restarts the fetch
   always_comb begin
      state_d  = state_q;
      rd_d     = 1'b0;
      raddr_d  = raddr_q;
      top_nc_d = top_nc_q;
      avail_d  = avail_q;
      valid_d  = valid_q;
      if (bus.mb_start_i) begin
         if (read_ok) begin
            state_d = S_RD;
            rd_d    = 1'b1;
            raddr_d = bus.mb_x_i;
            valid_d = 1'b0;
         end else begin
            state_d  = S_VALID;
            top_nc_d = '0;
            avail_d  = 1'b0;
            valid_d  = 1'b1;
         end
      end else begin
         case (state_q)
            S_RD:    state_d = S_WAIT;
            S_WAIT: begin
               state_d  = S_VALID;
               top_nc_d = capture_data;
               avail_d  = 1'b1;
               valid_d  = 1'b1;
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Registered read-side outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q     <= 1'b0;
         raddr_q  <= '0;
         top_nc_q <= '0;
         avail_q  <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         rd_q     <= rd_d;
         raddr_q  <= raddr_d;
         top_nc_q <= top_nc_d;
         avail_q  <= avail_d;
         valid_q  <= valid_d;
      end
   end

   // Write path: one-cycle write at the column latched at MB start; the old column is used
   // when done and start coincide because mb_x_q updates on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         we_q <= 1'b0;
         if (bus.mb_done_i) begin
            we_q    <= (mb_x_q < MB_MAX_C);
            waddr_q <= mb_x_q;
            wdata_q <= bus.bot_nc_i;
         end
      end
   end

   // Column of the current MB, latched at MB start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                mb_x_q <= '0;
      else if (bus.mb_start_i)   mb_x_q <= bus.mb_x_i;
   end

   assign bus.rd_o        = rd_q;
   assign bus.raddr_o     = raddr_q;
   assign bus.top_nc_o    = top_nc_q;
   assign bus.top_avail_o = avail_q;
   assign bus.top_valid_o = valid_q;
   assign bus.we_o        = we_q;
   assign bus.waddr_o     = waddr_q;
   assign bus.wdata_o     = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_cavlc_nc_top_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cavlc_nc_top_ctrl
//  Brief    : Directed self-checking bench for cavlc_nc_top_ctrl with a
//             read-first 2-port RAM model. Honours CAVLC_NC_FWD_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cavlc_nc_top_ctrl;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   logic [35:0] mem [0:127];

   cavlc_nc_top_ctrl_if #(.MB_X_W(7), .DATA_W(36)) bus ();

   cavlc_nc_top_ctrl #(.MB_X_W(7), .MB_MAX(120), .DATA_W(36)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Read-first RAM model: read data appears the cycle after rd_o
   always @(posedge clk) begin
      if (bus.rd_o) bus.rdata_i <= mem[bus.raddr_o];
      if (bus.we_o) mem[bus.waddr_o] <= bus.wdata_o;
   end

`ifndef CAVLC_NC_FWD_EN
   // Same-address read/write is illegal without forwarding
   always @(negedge clk) begin
      if (rst_n && bus.rd_o && bus.we_o && (bus.raddr_o == bus.waddr_o))
         $display("WARNING: same-address read/write at %0d, RAM returns old data", bus.raddr_o);
   end
`endif

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.mb_start_i = 1'b0;
      bus.mb_done_i  = 1'b0;
   endtask

   logic [35:0] hz_exp;

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 128; i++) mem[i] = '0;
      mem[119] = 36'h1_2345_6789;
      mem[8]   = 36'h8_8888_8888;
      mem[3]   = 36'h3_3333_3333;
      mem[4]   = 36'h4_4444_4444;
      mem[10]  = 36'h5_5555_5555;
      bus.rdata_i    = '0;
      bus.mb_start_i = 1'b0;
      bus.mb_x_i     = '0;
      bus.mb_y_i     = '0;
      bus.mb_done_i  = 1'b0;
      bus.bot_nc_i   = '0;
      rst_n = 1'b0;

      // ---- reset state
      repeat (3) @(negedge clk);
      chk("rst_valid", {35'd0, bus.top_valid_o}, 36'd0);
      chk("rst_avail", {35'd0, bus.top_avail_o}, 36'd0);
      chk("rst_nc",    bus.top_nc_o, 36'd0);
      chk("rst_rd",    {35'd0, bus.rd_o}, 36'd0);
      chk("rst_we",    {35'd0, bus.we_o}, 36'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // ---- start x=0,y=0: no read, valid at T+1
      bus.mb_start_i = 1'b1; bus.mb_x_i = 7'd0; bus.mb_y_i = 8'd0;
      @(negedge clk); idle_inputs();
      chk("y0_valid", {35'd0, bus.top_valid_o}, 36'd1);
      chk("y0_avail", {35'd0, bus.top_avail_o}, 36'd0);
      chk("y0_nc",    bus.top_nc_o, 36'd0);
      chk("y0_rd",    {35'd0, bus.rd_o}, 36'd0);
      @(negedge clk);
      chk("y0_rd2",   {35'd0, bus.rd_o}, 36'd0);

      // ---- row 0 MB x=5, write on done
      bus.mb_start_i = 1'b1; bus.mb_x_i = 7'd5; bus.mb_y_i = 8'd0;
      @(negedge clk); idle_inputs();
      bus.mb_done_i = 1'b1; bus.bot_nc_i = 36'h9_ABCD_1234;
      @(negedge clk); idle_inputs();
      chk("wr5_we",    {35'd0, bus.we_o}, 36'd1);
      chk("wr5_waddr", {29'd0, bus.waddr_o}, 36'd5);
      chk("wr5_wdata", bus.wdata_o, 36'h9_ABCD_1234);
      @(negedge clk);
      chk("wr5_we_off", {35'd0, bus.we_o}, 36'd0);

      // ---- row 1 MB x=5, read back
      bus.mb_start_i = 1'b1; bus.mb_x_i = 7'd5; bus.mb_y_i = 8'd1;
      @(negedge clk); idle_inputs();
      chk("rd5_rd",    {35'd0, bus.rd_o}, 36'd1);
      chk("rd5_raddr", {29'd0, bus.raddr_o}, 36'd5);
      chk("rd5_vdrop", {35'd0, bus.top_valid_o}, 36'd0);
      @(negedge clk);
      chk("rd5_rd_off", {35'd0, bus.rd_o}, 36'd0);
      chk("rd5_t2_valid", {35'd0, bus.top_valid_o}, 36'd0);
      @(negedge clk);
      chk("rd5_valid", {35'd0, bus.top_valid_o}, 36'd1);
      chk("rd5_avail", {35'd0, bus.top_avail_o}, 36'd1);
      chk("rd5_nc",    bus.top_nc_o, 36'h9_ABCD_1234);

      // ---- x=119 boundary, read allowed
      bus.mb_start_i = 1'b1; bus.mb_x_i = 7'd119; bus.mb_y_i = 8'd2;
      @(negedge clk); idle_inputs();
      chk("x119_rd",    {35'd0, bus.rd_o}, 36'd1);
      chk("x119_raddr", {29'd0, bus.raddr_o}, 36'd119);
      repeat (2) @(negedge clk);
      chk("x119_avail", {35'd0, bus.top_avail_o}, 36'd1);
      chk("x119_nc",    bus.top_nc_o, 36'h1_2345_6789);

      // ---- x=120 out of range: no read, no write
      bus.mb_start_i = 1'b1; bus.mb_x_i = 7'd120; bus.mb_y_i = 8'd2;
      @(negedge clk); idle_inputs();
      chk("x120_rd",    {35'd0, bus.rd_o}, 36'd0);
      chk("x120_valid", {35'd0, bus.top_valid_o}, 36'd1);
      chk("x120_avail", {35'd0, bus.top_avail_o}, 36'd0);
      chk("x120_nc",    bus.top_nc_o, 36'd0);
      bus.mb_done_i = 1'b1; bus.bot_nc_i = 36'hF_FFFF_FFFF;
      @(negedge clk); idle_inputs();
      chk("x120_we",    {35'd0, bus.we_o}, 36'd0);

      // ---- simultaneous done (latched x=7) and start x=8,y=3
      bus.mb_start_i = 1'b1; bus.mb_x_i = 7'd7; bus.mb_y_i = 8'd0;
      @(negedge clk); idle_inputs();
      bus.mb_done_i = 1'b1; bus.bot_nc_i = 36'hA_AAAA_0007;
      bus.mb_start_i = 1'b1; bus.mb_x_i = 7'd8; bus.mb_y_i = 8'd3;
      @(negedge clk); idle_inputs();
      chk("sim_we",    {35'd0, bus.we_o}, 36'd1);
      chk("sim_waddr", {29'd0, bus.waddr_o}, 36'd7);
      chk("sim_wdata", bus.wdata_o, 36'hA_AAAA_0007);
      chk("sim_rd",    {35'd0, bus.rd_o}, 36'd1);
      chk("sim_raddr", {29'd0, bus.raddr_o}, 36'd8);
      repeat (2) @(negedge clk);
      chk("sim_nc",    bus.top_nc_o, 36'h8_8888_8888);
      // entry 7 must now hold the written word
      bus.mb_start_i = 1'b1; bus.mb_x_i = 7'd7; bus.mb_y_i = 8'd4;
      @(negedge clk); idle_inputs();
      repeat (2) @(negedge clk);
      chk("sim_rb7",   bus.top_nc_o, 36'hA_AAAA_0007);

      // ---- back-to-back start aborts first fetch
      bus.mb_start_i = 1'b1; bus.mb_x_i = 7'd3; bus.mb_y_i = 8'd1;
      @(negedge clk);
      chk("ab_rd3",    {29'd0, bus.raddr_o}, 36'd3);
      bus.mb_x_i = 7'd4;
      @(negedge clk); idle_inputs();
      chk("ab_rd4",    {35'd0, bus.rd_o}, 36'd1);
      chk("ab_raddr4", {29'd0, bus.raddr_o}, 36'd4);
      @(negedge clk);
      chk("ab_t3_valid", {35'd0, bus.top_valid_o}, 36'd0);
      chk("ab_t3_rd",    {35'd0, bus.rd_o}, 36'd0);
      @(negedge clk);
      chk("ab_t4_valid", {35'd0, bus.top_valid_o}, 36'd1);
      chk("ab_t4_nc",    bus.top_nc_o, 36'h4_4444_4444);

      // ---- same-address hazard at entry 10
      bus.mb_start_i = 1'b1; bus.mb_x_i = 7'd10; bus.mb_y_i = 8'd0;
      @(negedge clk); idle_inputs();
      bus.mb_done_i = 1'b1; bus.bot_nc_i = 36'h0_0000_0001;
      bus.mb_start_i = 1'b1; bus.mb_x_i = 7'd10; bus.mb_y_i = 8'd1;
      @(negedge clk); idle_inputs();
      chk("hz_rd",  {35'd0, bus.rd_o}, 36'd1);
      chk("hz_we",  {35'd0, bus.we_o}, 36'd1);
      chk("hz_addr", {29'd0, bus.waddr_o}, 36'd10);
      repeat (2) @(negedge clk);
`ifdef CAVLC_NC_FWD_EN
      hz_exp = 36'h0_0000_0001;
`else
      hz_exp = 36'h5_5555_5555;
`endif
      chk("hz_nc",    bus.top_nc_o, hz_exp);
      chk("hz_valid", {35'd0, bus.top_valid_o}, 36'd1);

      // ---- reset in the middle of a fetch
      bus.mb_start_i = 1'b1; bus.mb_x_i = 7'd11; bus.mb_y_i = 8'd1;
      @(negedge clk); idle_inputs();
      rst_n = 1'b0;
      #1;
      chk("mrst_rd",    {35'd0, bus.rd_o}, 36'd0);
      chk("mrst_valid", {35'd0, bus.top_valid_o}, 36'd0);
      chk("mrst_nc",    bus.top_nc_o, 36'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("mrst_idle", {35'd0, bus.top_valid_o}, 36'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
